// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// ALU control codes, ALU operation classes and the FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALUOP_NONE parks alu_ctrl at zero in states that do not use the ALU
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } alu_op_t;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC     = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_ADDI_EX  = 4'd11;
    localparam logic [3:0] S_ADDI_WB  = 4'd12;

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational ALU control decoder: maps the FSM's ALU operation class and
// the R-type funct field onto the ALU control code.
module alu_decode
    import mips_pkg::*;
#(
    parameter int FN_W       = 6,
    parameter int ALU_CTRL_W = 4
) (
    input  alu_op_t               alu_op,
    input  logic [FN_W-1:0]       funct,
    output logic [ALU_CTRL_W-1:0] alu_ctrl
);

    logic [3:0] code;

    // Unknown funct values fall back to add rather than being flagged
    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_W'(FN_ADD): code = ALU_ADD;
                    FN_W'(FN_SUB): code = ALU_SUB;
                    FN_W'(FN_AND): code = ALU_AND;
                    FN_W'(FN_OR):  code = ALU_OR;
                    FN_W'(FN_SLT): code = ALU_SLT;
                    default:       code = ALU_ADD;
                endcase
            end
            default: code = 4'b0000;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute for R-type,
// lw, sw, beq, j and optional addi, and counts retired instructions.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int FN_W       = 6,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32,
    parameter int EN_ADDI    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       op,
    input  logic [FN_W-1:0]       funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal_op,
    output logic                  instr_done,
    output logic [CNT_W-1:0]      retired
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       armed;
    alu_op_t    alu_op;

    logic is_rtype, is_lw, is_sw, is_beq, is_j, is_addi, legal;

    assign is_rtype = (op == OP_W'(OP_RTYPE));
    assign is_lw    = (op == OP_W'(OP_LW));
    assign is_sw    = (op == OP_W'(OP_SW));
    assign is_beq   = (op == OP_W'(OP_BEQ));
    assign is_j     = (op == OP_W'(OP_J));
    assign is_addi  = (op == OP_W'(OP_ADDI)) && (EN_ADDI != 0);
    assign legal    = is_rtype | is_lw | is_sw | is_beq | is_j | is_addi;

    // armed holds IDLE for one extra edge after reset release, so the first
    // FETCH lands on the second edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            armed   <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (instr_done) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (armed) state_nxt = S_FETCH;
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_rtype)            state_nxt = S_EXEC;
                else if (is_lw || is_sw) state_nxt = S_MEM_ADDR;
                else if (is_beq)         state_nxt = S_BRANCH;
                else if (is_j)           state_nxt = S_JUMP;
                else if (is_addi)        state_nxt = S_ADDI_EX;
                else                     state_nxt = S_FETCH;
            end
            S_MEM_ADDR: state_nxt = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WB:   state_nxt = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
            S_EXEC:     state_nxt = S_ALU_WB;
            S_ALU_WB:   state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JUMP:     state_nxt = S_FETCH;
            S_ADDI_EX:  state_nxt = S_ADDI_WB;
            S_ADDI_WB:  state_nxt = S_FETCH;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Strobes follow the registered state; mem_ready only gates the fetch
    // writes and the store retire. In BRANCH pc_write also follows zero so a
    // taken branch is visible without external gating.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        alu_op        = ALUOP_NONE;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_op     = ALUOP_ADD;
                illegal_op = ~legal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                pc_write      = zero;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decode #(
        .FN_W       (FN_W),
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decode (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width.
REQ-002 SHALL have parameter FN_W, default 6, funct width.
REQ-003 SHALL have parameter ALU_CTRL_W, default 4, ALU control width.
REQ-004 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-005 SHALL have parameter EN_ADDI, default 1; when 1, addi is legal; when 0, addi is illegal.
REQ-006 SHALL provide ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- op  in  OP_W  opcode from the instruction register.
- funct  in  FN_W  funct field.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake acknowledge.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1  datapath strobes and selects.
- alu_src_b, pc_src  out  2  mux selects.
- alu_ctrl  out  ALU_CTRL_W  ALU operation.
- illegal_op  out  1  one-cycle unknown-opcode pulse.
- instr_done  out  1  one-cycle retire pulse.
- retired  out  CNT_W  retired-instruction count.
REQ-007 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-008 SHALL implement states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB.
REQ-009 Outputs SHALL be decoded from the registered state; only ir_write, pc_write, instr_done and state advance are qualified by mem_ready.
REQ-010 IDLE SHALL drive all outputs to 0 and advance to FETCH on the next clk.
REQ-011 FETCH SHALL assert mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 and ALU add; it SHALL hold while mem_ready=0; when mem_ready=1 it SHALL pulse ir_write=1 and pc_write=1 and go to DECODE.
REQ-012 DECODE SHALL compute branch target (alu_src_a=0, alu_src_b=11, add) and go to: R-type 000000 -> EXEC; lw 100011 / sw 101011 -> MEM_ADDR; beq 000100 -> BRANCH; j 000010 -> JUMP; addi 001000 (EN_ADDI=1) -> ADDI_EX; any other opcode -> pulse illegal_op, then FETCH, with no writes.
REQ-013 MEM_ADDR SHALL use alu_src_a=1, alu_src_b=10, add; lw -> MEM_RD, sw -> MEM_WR.
REQ-014 MEM_RD SHALL assert mem_read and i_or_d=1, hold until mem_ready, then go to MEM_WB.
REQ-015 MEM_WB SHALL assert reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-016 MEM_WR SHALL assert mem_write and i_or_d=1, hold until mem_ready, then retire.
REQ-017 EXEC SHALL use alu_src_a=1, alu_src_b=00, and alu_ctrl from funct; ALU_WB SHALL assert reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-018 BRANCH SHALL assert pc_write_cond=1, pc_src=01, and ALU subtract; the PC updates only when zero=1.
REQ-019 JUMP SHALL assert pc_write=1, pc_src=10.
REQ-020 ADDI_EX SHALL use alu_src_b=10 with add; ADDI_WB SHALL assert reg_write=1, reg_dst=0.
REQ-021 The terminal states MEM_WB, MEM_WR (with mem_ready), ALU_WB, BRANCH, JUMP and ADDI_WB SHALL pulse instr_done, increment retired, and return to FETCH.
REQ-022 retired SHALL wrap from all-ones to 0; it SHALL not increment on illegal opcodes.
REQ-023 With zero-wait memory, latency SHALL be: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
REQ-024 Unknown funct in EXEC SHALL map alu_ctrl to add and SHALL not flag illegal_op.

Reset
REQ-025 Asserting rst at any time, including during a memory wait, SHALL force state IDLE, all strobes 0, and retired 0 asynchronously; the first FETCH SHALL follow two clk edges after deassertion.

Structure
REQ-026 The opcode constants, state encoding, and ALU operation codes SHALL live in a shared package, mips_pkg.
REQ-027 The funct/alu_op-to-alu_ctrl mapping SHALL be a combinational sub-module named alu_decode.

Verification
REQ-028 Bench SHALL check: lw (op 100011) with mem_ready tied 1 -> instr_done in cycle 5 after FETCH entry, reg_write=1 with mem_to_reg=1 in MEM_WB.
REQ-029 Bench SHALL check: sw with mem_ready low for 3 cycles in MEM_WR -> mem_write held for 4 cycles, retired +1, reg_write never 1.
REQ-030 Bench SHALL check: beq with zero=0, then beq with zero=1 -> pc_write_cond=1 and pc_src=01 both times, 3 cycles each.
REQ-031 Bench SHALL check: op 111111, then addi with EN_ADDI=0 -> illegal_op pulses once each, retired unchanged, next state FETCH.
REQ-032 Bench SHALL check: rst pulsed mid MEM_RD -> all outputs 0 immediately, retired=0, mem_read reasserted 2 edges after release.
REQ-033 Bench SHALL check: CNT_W=3 with 9 R-type instructions (funct 100000) -> retired wraps to 1, alu_ctrl=add.
